// File: rtl/matrix_delay_line_pkg.sv
// Shared types and helpers for the programmable matrix delay line.
package matrix_delay_pkg;

    typedef enum logic {
        FILL,
        RUN
    } dl_state_t;

    // Map a requested delay onto the supported range 1..max_delay.
    function automatic logic [31:0] clamp_delay(input logic [31:0] value,
                                                input logic [31:0] max_delay);
        if (value == 32'd0) begin
            return 32'd1;
        end
        if (value > max_delay) begin
            return max_delay;
        end
        return value;
    endfunction

endpackage

// File: rtl/matrix_delay_line_dl_ring_ram.sv
// Register ring of MAX_DELAY entries, each a flattened matrix plus a valid bit.
// One write port, one asynchronous read port, and a strobe that clears every valid bit.
module dl_ring_ram
    import matrix_delay_pkg::*;
#(
    parameter int unsigned MAX_DELAY = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned R         = 2,
    parameter int unsigned C         = 2,
    localparam int unsigned AW       = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [AW-1:0]                    waddr,
    input  logic                             wvalid,
    input  logic [R-1:0][C-1:0][WIDTH-1:0]   wdata,
    input  logic [AW-1:0]                    raddr,
    output logic                             rvalid,
    output logic [R-1:0][C-1:0][WIDTH-1:0]   rdata,
    input  logic                             clr
);

    localparam int unsigned EW = R * C * WIDTH + 1;

    logic [EW-1:0] mem_q [MAX_DELAY];
    logic [EW-1:0] mem_d [MAX_DELAY];

    // A write in the same cycle as a clear survives: it is the first sample of the new epoch.
    always_comb begin
        for (int unsigned i = 0; i < MAX_DELAY; i++) begin
            mem_d[i] = mem_q[i];
            if (clr) begin
                mem_d[i][EW-1] = 1'b0;
            end
            if (we && (waddr == AW'(i))) begin
                mem_d[i] = {wvalid, wdata};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_DELAY; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MAX_DELAY; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign {rvalid, rdata} = mem_q[raddr];

endmodule

// File: rtl/matrix_delay_line.sv
// Runtime-programmable delay line for an R x C matrix with valid, stall and reconfigure/flush.
// Optional build macro MATRIX_DELAY_LINE_CNT_EN adds a saturating vld_count output.
module matrix_delay_line
    import matrix_delay_pkg::*;
#(
    parameter int unsigned MAX_DELAY = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned R         = 2,
    parameter int unsigned C         = 2,
    localparam int unsigned DW       = $clog2(MAX_DELAY + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             cfg_load,
    input  logic [DW-1:0]                    cfg_delay,
    output logic                             busy,
    input  logic                             in_valid,
    input  logic [R-1:0][C-1:0][WIDTH-1:0]   a,
    output logic                             out_valid,
    output logic [R-1:0][C-1:0][WIDTH-1:0]   c
`ifdef MATRIX_DELAY_LINE_CNT_EN
    ,
    output logic [31:0]                      vld_count
`endif
);

    localparam int unsigned AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam int unsigned SW = AW + 1;

    typedef logic [R-1:0][C-1:0][WIDTH-1:0] mat_t;

    logic [DW-1:0] delay_q, delay_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wptr_q, wptr_d;
    dl_state_t     state_q, state_d;
    logic          out_valid_q, out_valid_d;
    mat_t          c_q, c_d;

    logic [DW-1:0] load_delay;
    logic [SW-1:0] rd_sum;
    logic [AW-1:0] rd_idx;
    logic          rd_valid;
    mat_t          rd_data;

    assign load_delay = DW'(clamp_delay(32'(cfg_delay), MAX_DELAY));

    // Read slot (wptr - D + 1) mod MAX_DELAY, kept non-negative by adding MAX_DELAY first.
    always_comb begin
        rd_sum = {1'b0, wptr_q} + SW'(MAX_DELAY + 1 - 32'(delay_q));
        if (rd_sum >= SW'(MAX_DELAY)) begin
            rd_sum = rd_sum - SW'(MAX_DELAY);
        end
        rd_idx = rd_sum[AW-1:0];
    end

    dl_ring_ram #(
        .MAX_DELAY (MAX_DELAY),
        .WIDTH     (WIDTH),
        .R         (R),
        .C         (C)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .we     (en),
        .waddr  (wptr_q),
        .wvalid (in_valid),
        .wdata  (a),
        .raddr  (rd_idx),
        .rvalid (rd_valid),
        .rdata  (rd_data),
        .clr    (cfg_load)
    );

    always_comb begin
        delay_d = delay_q;
        wptr_d  = wptr_q;
        if (cfg_load) begin
            delay_d = load_delay;
        end
        if (en) begin
            wptr_d = (wptr_q == AW'(MAX_DELAY - 1)) ? '0 : wptr_q + AW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cfg_load) begin
            state_d = FILL;
            cnt_d   = load_delay;
        end else if ((state_q == FILL) && en) begin
            if (cnt_q == DW'(1)) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - DW'(1);
            end
        end
    end

    // With D=1 the read slot is the one being written this cycle, so forward the input.
    always_comb begin
        c_d         = c_q;
        out_valid_d = out_valid_q;
        if (en) begin
            if (delay_q == DW'(1)) begin
                c_d         = a;
                out_valid_d = in_valid;
            end else begin
                c_d         = rd_data;
                out_valid_d = rd_valid;
            end
        end
        if (cfg_load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q     <= DW'(1);
            cnt_q       <= DW'(1);
            wptr_q      <= '0;
            state_q     <= FILL;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            delay_q     <= delay_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
        end
    end

    assign busy      = (state_q == FILL);
    assign out_valid = out_valid_q;
    assign c         = c_q;

`ifdef MATRIX_DELAY_LINE_CNT_EN
    logic [31:0] vld_count_q, vld_count_d;

    always_comb begin
        vld_count_d = vld_count_q;
        if (cfg_load) begin
            vld_count_d = '0;
        end else if (en && out_valid_q && (vld_count_q != '1)) begin
            vld_count_d = vld_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_count_q <= '0;
        end else begin
            vld_count_q <= vld_count_d;
        end
    end

    assign vld_count = vld_count_q;
`endif

endmodule
